regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port integer register file, successor to the single-port register array in the CPU datapath. It provides NRD asynchronous read ports and one synchronous write port. Reset clears the file one entry per cycle with a sequencer, so no wide reset fan-out is needed. Optional write-to-read bypass and an optional hardwired-zero entry 0 support both RV32I and scratch-register uses.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of entries (2..64; need not be a power of two)
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 reads constant 0 and ignores writes
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
- IW (derived), $clog2(NREGS), index width

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_idx  in  NRD*IW  read indices; port k uses bits [k*IW +: IW]
- rd_data  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]; combinational
- wr_en  in  1  write strobe
- wr_idx  in  IW  write index
- wr_data  in  XLEN  write data
- busy  out  1  clear sequence in progress
- wr_err  out  1  registered one-cycle pulse: a write was dropped

## Operation
- FSM states: CLEAR and READY.
- While rst = 1 at a clk edge:
  - state <= CLEAR.
  - clr_ptr <= first clearable index: 1 if ZERO_REG, else 0.
  - wr_err <= 0.
- CLEAR, rst = 0:
  - Each edge writes 0 to entry clr_ptr, then increments clr_ptr.
  - After the edge that clears entry NREGS-1, state <= READY.
- busy = (state == CLEAR). busy is therefore 1 during and immediately after reset.
- Reads (combinational, per port):
  - busy = 1 → 0.
  - rd_idx >= NREGS → 0.
  - ZERO_REG and rd_idx == 0 → 0.
  - BYPASS, wr_en, wr_idx == rd_idx, write is legal → wr_data.
  - Otherwise → stored entry.
- Write in READY:
  - wr_en with wr_idx < NREGS and not (ZERO_REG and wr_idx == 0) → entry <= wr_data at the edge.
  - wr_en with wr_idx == 0 and ZERO_REG → silently ignored, no error.
- Dropped write: wr_en while busy, or wr_idx >= NREGS → no storage change, wr_err = 1 for the following cycle.
- Rst asserted mid-CLEAR restarts the sequence from the first clearable index. The partially cleared contents do not matter.
- Rst has priority over everything. A write in the same cycle as rst is dropped, and wr_err stays 0.

## Timing
- Reset values: busy = 1, wr_err = 0, rd_data = 0 on every port.
- Clear length: NREGS-1 cycles after rst deasserts with ZERO_REG = 1; NREGS cycles with ZERO_REG = 0.
  - busy falls at the edge that clears the last entry.
  - First accepted write is in the cycle busy reads 0.
- Write-to-read latency:
  - BYPASS = 1: 0 cycles. Data is visible combinationally in the write cycle.
  - BYPASS = 0: 1 cycle. Data is visible after the write edge.
- Read ports are fully independent. Any number of ports may address the same index, with identical results.
- wr_err is registered: it is high exactly one cycle after the offending wr_en cycle, then returns to 0. Consecutive bad writes hold it high.
- No combinational path from rd_idx to busy or wr_err.

## Test plan
- Reset sequence (defaults): 1 cycle rst, then count busy.
  - busy = 1 for exactly 31 cycles after rst falls, then 0.
  - All ports read 0 for every index throughout.
- Basic write/read (BYPASS = 1): write 0xDEADBEEF to x5.
  - rd0 = 5 returns 0xDEADBEEF in the same cycle and after.
  - rd1 = 6 returns 0.
- Zero register: write 0x12345678 to x0.
  - Both ports read 0 for x0.
  - wr_err stays 0.
- Write during busy: write to x3 during the 10th clear cycle.
  - wr_err = 1 the next cycle.
  - x3 reads 0 after busy falls.
- Mid-clear reset: rst again at clear cycle 15.
  - busy stays high for 31 cycles after the second rst falls.
  - Earlier-written x7 = 0xAAAA0000 reads 0 afterwards.
- NREGS = 24, BYPASS = 0, ZERO_REG = 0, NRD = 3:
  - Clear lasts 24 cycles.
  - Write 0x55 to x23: visible the next cycle only, not in the write cycle.
  - Write to x30: wr_err = 1, and rd_idx = 30 returns 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port register file with one synchronous write port and a
// sequenced clear after reset (one entry per cycle).
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int IW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*IW-1:0]   rd_idx,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                wr_en,
    input  logic [IW-1:0]       wr_idx,
    input  logic [XLEN-1:0]     wr_data,
    output logic                busy,
    output logic                wr_err
);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    localparam logic [IW-1:0] FIRST   = (ZERO_REG != 0) ? IW'(1) : '0;
    localparam logic [IW-1:0] LAST    = IW'(NREGS - 1);
    localparam logic [IW:0]   NREGS_W = (IW + 1)'(NREGS);

    state_t            state;
    logic [IW-1:0]     clr_ptr;
    logic [XLEN-1:0]   mem [NREGS];
    logic              wr_legal;

    function automatic logic in_range(input logic [IW-1:0] idx);
        return {1'b0, idx} < NREGS_W;
    endfunction

    function automatic logic is_zero_reg(input logic [IW-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    assign busy     = (state == CLEAR);
    assign wr_legal = wr_en && in_range(wr_idx) && !is_zero_reg(wr_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= FIRST;
            wr_err  <= 1'b0;
        end else begin
            wr_err <= wr_en && ((state == CLEAR) || !in_range(wr_idx));
            if (state == CLEAR) begin
                if (clr_ptr == LAST) begin
                    state <= READY;
                end else begin
                    clr_ptr <= clr_ptr + 1'b1;
                end
            end
        end
    end

    // Storage has no reset of its own; the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (wr_legal) begin
                mem[wr_idx] <= wr_data;
            end
        end
    end

    always_comb begin
        logic [IW-1:0] ri;
        ri      = '0;
        rd_data = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            ri = rd_idx[k*IW +: IW];
            if (!busy && in_range(ri) && !is_zero_reg(ri)) begin
                if ((BYPASS != 0) && wr_legal && (wr_idx == ri)) begin
                    rd_data[k*XLEN +: XLEN] = wr_data;
                end else begin
                    rd_data[k*XLEN +: XLEN] = mem[ri];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: two configurations driven in lock-step,
// expectations from an array model pushed per cycle and checked on negedge.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [31:0] wr_data;
    logic [4:0]  sel [2][3];

    logic [9:0]  rd_idx_a;
    logic [63:0] rd_data_a;
    logic        busy_a, wr_err_a;
    logic [14:0] rd_idx_b;
    logic [95:0] rd_data_b;
    logic        busy_b, wr_err_b;

    assign rd_idx_a = {sel[0][1], sel[0][0]};
    assign rd_idx_b = {sel[1][2], sel[1][1], sel[1][0]};

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .rd_idx(rd_idx_a), .rd_data(rd_data_a),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .busy(busy_a), .wr_err(wr_err_a)
    );

    regfile_mp #(.XLEN(32), .NREGS(24), .NRD(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rd_idx(rd_idx_b), .rd_data(rd_data_b),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .busy(busy_b), .wr_err(wr_err_b)
    );

    typedef struct packed {
        logic [1:0]       busy;
        logic [1:0]       err;
        logic [5:0][31:0] rd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: configuration d=0 is dut_a, d=1 is dut_b.
    logic [31:0] mem [2][32];
    int          clr_left [2];
    logic        err_m [2];

    function automatic int n_of(int d);   return (d == 0) ? 32 : 24; endfunction
    function automatic bit zr_of(int d);  return d == 0;             endfunction
    function automatic bit byp_of(int d); return d == 0;             endfunction
    function automatic int nrd_of(int d); return (d == 0) ? 2 : 3;   endfunction

    function automatic bit legal(int d);
        return wr_en && (int'(wr_idx) < n_of(d)) && !(zr_of(d) && wr_idx == 0);
    endfunction

    function automatic logic [31:0] model_rd(int d, int k);
        int idx = int'(sel[d][k]);
        if (clr_left[d] > 0) return '0;
        if (idx >= n_of(d)) return '0;
        if (zr_of(d) && idx == 0) return '0;
        if (byp_of(d) && legal(d) && int'(wr_idx) == idx) return wr_data;
        return mem[d][idx];
    endfunction

    task automatic model_edge(int d);
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[d][i] = '0;
            clr_left[d] = zr_of(d) ? n_of(d) - 1 : n_of(d);
            err_m[d]    = 1'b0;
        end else begin
            err_m[d] = wr_en && (clr_left[d] > 0 || int'(wr_idx) >= n_of(d));
            if (clr_left[d] > 0) clr_left[d]--;
            else if (legal(d)) mem[d][wr_idx] = wr_data;
        end
    endtask

    task automatic cycle();
        exp_t e;
        e = '0;
        for (int d = 0; d < 2; d++) begin
            e.busy[d] = clr_left[d] > 0;
            e.err[d]  = err_m[d];
            for (int k = 0; k < nrd_of(d); k++) e.rd[d*3+k] = model_rd(d, k);
        end
        q.push_back(e);
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic        ab, ae;
            logic [31:0] ad;
            e = q.pop_front();
            for (int d = 0; d < 2; d++) begin
                ab = (d == 0) ? busy_a : busy_b;
                ae = (d == 0) ? wr_err_a : wr_err_b;
                checks++;
                if (ab !== e.busy[d]) begin
                    errors++;
                    $display("FAIL busy dut%0d t=%0t: got %b expected %b", d, $time, ab, e.busy[d]);
                end
                checks++;
                if (ae !== e.err[d]) begin
                    errors++;
                    $display("FAIL wr_err dut%0d t=%0t: got %b expected %b", d, $time, ae, e.err[d]);
                end
                for (int k = 0; k < nrd_of(d); k++) begin
                    ad = (d == 0) ? rd_data_a[k*32 +: 32] : rd_data_b[k*32 +: 32];
                    checks++;
                    if (ad !== e.rd[d*3+k]) begin
                        errors++;
                        $display("FAIL rd dut%0d port%0d idx=%0d t=%0t: got %h expected %h",
                                 d, k, sel[d][k], $time, ad, e.rd[d*3+k]);
                    end
                end
            end
        end
    end

    task automatic set_sel(logic [4:0] v);
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 3; k++) sel[d][k] = v;
    endtask

    task automatic rand_sel();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 3; k++)
                sel[d][k] = ($urandom_range(3) == 0) ? wr_idx : 5'($urandom_range(31));
    endtask

    task automatic write(logic [4:0] idx, logic [31:0] data);
        wr_en = 1'b1; wr_idx = idx; wr_data = data;
    endtask

    // One rst cycle then len cycles; optionally a write to x3 at clear cycle wr_at+1.
    task automatic reset_and_clear(int len, int wr_at, bit chk);
        int cnt_a = 0, cnt_b = 0;
        rst = 1'b1; wr_en = 1'b0;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < len; i++) begin
            cnt_a += int'(busy_a);
            cnt_b += int'(busy_b);
            if (i == wr_at) write(5'd3, $urandom);
            else wr_en = 1'b0;
            rand_sel();
            cycle();
        end
        wr_en = 1'b0;
        if (chk) begin
            checks++;
            if (cnt_a != 31) begin
                errors++;
                $display("FAIL clear_len dut0: got %0d expected 31", cnt_a);
            end
            checks++;
            if (cnt_b != 24) begin
                errors++;
                $display("FAIL clear_len dut1: got %0d expected 24", cnt_b);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
        set_sel(5'd0);
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;

        reset_and_clear(35, 9, 1'b1);
        set_sel(5'd3);
        cycle();

        write(5'd5, 32'hDEADBEEF);
        set_sel(5'd5);
        sel[0][1] = 5'd6;
        cycle();
        wr_en = 1'b0;
        cycle();

        write(5'd0, 32'h12345678);
        set_sel(5'd0);
        cycle();
        wr_en = 1'b0;
        cycle();

        write(5'd23, 32'h55);
        set_sel(5'd23);
        cycle();
        wr_en = 1'b0;
        cycle();
        cycle();

        write(5'd30, $urandom);
        set_sel(5'd30);
        cycle();
        wr_en = 1'b0;
        cycle();

        write(5'd7, 32'hAAAA0000);
        set_sel(5'd7);
        cycle();
        wr_en = 1'b0;
        cycle();
        reset_and_clear(15, -1, 1'b0);
        reset_and_clear(35, -1, 1'b1);
        set_sel(5'd7);
        cycle();

        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(149) == 0);
            wr_en   = $urandom_range(1);
            wr_idx  = 5'($urandom_range(31));
            wr_data = $urandom;
            rand_sel();
            cycle();
        end
        rst = 1'b0; wr_en = 1'b0;

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
